// File: rtl/fpu_seq_pkg.sv
// fpu_seq_pkg
// Shared types for the FP issue sequencer.
//   state_t : sequencer states (IDLE/BUSY/WB/ABORT)
//   fp_op_t : FPU opcode encodings (ADD=0, SUB=1, MUL=2, DIV=3)
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    WB    = 2'd2,
    ABORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_SUB = 2'd1,
    FP_MUL = 2'd2,
    FP_DIV = 2'd3
  } fp_op_t;

endpackage

// File: rtl/fpu_watchdog.sv
// fpu_watchdog
// Cycle counter guarding an in-flight FPU operation.
//   CLK, Reset : clock, asynchronous active-high reset
//   clr        : restart the count at zero (launch cycle)
//   en         : count this cycle (operation outstanding)
//   expired    : count has reached TIMEOUT-1, i.e. this is the last
//                cycle the operation may still complete
module fpu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && !expired) begin
      // Holds at the limit; the sequencer leaves BUSY on that cycle anyway.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
// Sequencer between the core's decode/condition stage and a multi-cycle FPU.
// Launches one FPU op per condition-passing FP instruction, stalls the core
// while the FPU works, then issues a one-cycle register write (and optional
// flag write). A watchdog aborts operations that never complete.
//   Inputs : CLK, Reset, FPUReq, CondEx, FPOp, FPDst, FPS,
//            FPUDone, FPUResult, FPUFlags, ErrClr
//   Outputs: FPUStart, FPUOpOut, FPUAbort, Stall, FPUWrite, FPWA, FPWD,
//            FPFlagW, FPFlags, Err, OpCount
module fpu_issue_ctrl
  import fpu_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              FPUReq,
  input  logic              CondEx,
  input  logic [1:0]        FPOp,
  input  logic [3:0]        FPDst,
  input  logic              FPS,
  input  logic              FPUDone,
  input  logic [DATA_W-1:0] FPUResult,
  input  logic [3:0]        FPUFlags,
  input  logic              ErrClr,
  output logic              FPUStart,
  output logic [1:0]        FPUOpOut,
  output logic              FPUAbort,
  output logic              Stall,
  output logic              FPUWrite,
  output logic [3:0]        FPWA,
  output logic [DATA_W-1:0] FPWD,
  output logic [1:0]        FPFlagW,
  output logic [3:0]        FPFlags,
  output logic              Err,
  output logic [CNT_W-1:0]  OpCount
);

  state_t              state_reg;
  logic [3:0]          dst_reg;
  logic                fps_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [3:0]          flags_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                err_reg;
  logic                launch;
  logic                wd_expired;
  logic                in_wb;

  // Launch is decided combinationally so the core freezes in the same cycle.
  // Gating with Reset keeps every output quiet while reset is held.
  assign launch = (state_reg == IDLE) && FPUReq && CondEx && !Reset;

  fpu_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK    (CLK),
    .Reset  (Reset),
    .clr    (launch),
    .en     (state_reg == BUSY),
    .expired(wd_expired)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      dst_reg    <= '0;
      fps_reg    <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A done pulse seen here is spurious (or same-cycle as launch) and is ignored.
          if (launch) begin
            dst_reg   <= FPDst;
            fps_reg   <= FPS;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // Completion takes priority over the watchdog on the limit cycle.
          if (FPUDone) begin
            result_reg <= FPUResult;
            flags_reg  <= FPUFlags;
            state_reg  <= WB;
          end else if (wd_expired) begin
            state_reg <= ABORT;
          end
        end
        WB: begin
          if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
          state_reg <= IDLE;
        end
        ABORT: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sticky error: the abort cycle sets it and beats a simultaneous clear.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == ABORT) begin
      err_reg <= 1'b1;
    end else if (ErrClr) begin
      err_reg <= 1'b0;
    end
  end

  assign in_wb    = (state_reg == WB);
  assign FPUStart = launch;
  assign FPUOpOut = launch ? FPOp : 2'b00;
  assign Stall    = launch || (state_reg == BUSY);
  assign FPUAbort = (state_reg == ABORT);
  assign FPUWrite = in_wb;
  assign FPWA     = in_wb ? dst_reg : 4'd0;
  assign FPWD     = in_wb ? result_reg : '0;
  assign FPFlagW  = (in_wb && fps_reg) ? 2'b11 : 2'b00;
  assign FPFlags  = in_wb ? flags_reg : 4'd0;
  assign Err      = err_reg;
  assign OpCount  = cnt_reg;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl
// Table of directed FP instructions, hand-written reset / spurious-done
// sequences, then randomized instructions checked against a
// transaction-level model of the sequencer's rules.
module tb_fpu_issue_ctrl;
  import fpu_seq_pkg::*;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 4;

  logic              CLK = 1'b0;
  logic              Reset;
  logic              FPUReq, CondEx, FPS, FPUDone, ErrClr;
  logic [1:0]        FPOp;
  logic [3:0]        FPDst, FPUFlags;
  logic [DATA_W-1:0] FPUResult;
  logic              FPUStart, FPUAbort, Stall, FPUWrite, Err;
  logic [1:0]        FPUOpOut, FPFlagW;
  logic [3:0]        FPWA, FPFlags;
  logic [DATA_W-1:0] FPWD;
  logic [CNT_W-1:0]  OpCount;

  fpu_issue_ctrl #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .FPUReq(FPUReq), .CondEx(CondEx), .FPOp(FPOp),
    .FPDst(FPDst), .FPS(FPS), .FPUDone(FPUDone), .FPUResult(FPUResult),
    .FPUFlags(FPUFlags), .ErrClr(ErrClr), .FPUStart(FPUStart), .FPUOpOut(FPUOpOut),
    .FPUAbort(FPUAbort), .Stall(Stall), .FPUWrite(FPUWrite), .FPWA(FPWA),
    .FPWD(FPWD), .FPFlagW(FPFlagW), .FPFlags(FPFlags), .Err(Err), .OpCount(OpCount)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int unsigned m_cnt = 0;
  bit m_err = 1'b0;
  int op_no = 0;

  typedef struct {
    bit              req;
    bit              cond;
    logic [1:0]      op;
    logic [3:0]      dst;
    bit              s;
    int              done_at;    // BUSY cycle (1-based) carrying FPUDone
    logic [31:0]     result;
    logic [3:0]      flags;
    bit              clr_first;  // ErrClr in the request cycle
    bit              clr_end;    // ErrClr in the WB/ABORT cycle
    bit              exp_start;
    bit              exp_write;
    logic [1:0]      exp_flagw;
    int              exp_stall;  // cycles with Stall high
    logic [CNT_W-1:0] exp_cnt;
    bit              exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {11'd0, FPUStart, Stall, FPUOpOut, FPUAbort, FPUWrite, FPWA, FPWD,
            FPFlagW, FPFlags, Err, OpCount};
  endfunction

  function automatic vec_t mk(bit req, bit cond, logic [1:0] op, logic [3:0] dst, bit s,
                              int done_at, logic [31:0] result, logic [3:0] flags,
                              bit clr_first, bit clr_end, bit exp_start, bit exp_write,
                              logic [1:0] exp_flagw, int exp_stall,
                              logic [CNT_W-1:0] exp_cnt, bit exp_err);
    vec_t v;
    v.req = req; v.cond = cond; v.op = op; v.dst = dst; v.s = s;
    v.done_at = done_at; v.result = result; v.flags = flags;
    v.clr_first = clr_first; v.clr_end = clr_end;
    v.exp_start = exp_start; v.exp_write = exp_write; v.exp_flagw = exp_flagw;
    v.exp_stall = exp_stall; v.exp_cnt = exp_cnt; v.exp_err = exp_err;
    return v;
  endfunction

  // Transaction-level reference: outcome of one instruction from the rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    bit e = m_err;
    int unsigned c = m_cnt;
    r.exp_start = v.req && v.cond;
    r.exp_write = 1'b0;
    r.exp_flagw = 2'b00;
    r.exp_stall = 0;
    if (v.clr_first) e = 1'b0;
    if (r.exp_start) begin
      if (v.done_at <= TIMEOUT) begin
        r.exp_write = 1'b1;
        r.exp_flagw = v.s ? 2'b11 : 2'b00;
        r.exp_stall = v.done_at + 1;
        if (c < (2 ** CNT_W) - 1) c++;
        if (v.clr_end) e = 1'b0;
      end else begin
        r.exp_stall = TIMEOUT + 1;
        e = 1'b1;
      end
    end
    r.exp_cnt = c[CNT_W-1:0];
    r.exp_err = e;
    return r;
  endfunction

  task automatic run_op(input vec_t v);
    // Request cycle
    @(negedge CLK);
    FPUReq = v.req; CondEx = v.cond; FPOp = v.op; FPDst = v.dst; FPS = v.s;
    FPUDone = 1'b0; FPUResult = $urandom; FPUFlags = 4'($urandom); ErrClr = v.clr_first;
    #1;
    chk("start", FPUStart, v.exp_start);
    chk("stall0", Stall, v.exp_start);
    chk("opout", FPUOpOut, v.exp_start ? v.op : 2'b00);
    chk("write0", FPUWrite, 1'b0);
    if (v.exp_start) begin
      for (int c = 1; c <= v.exp_stall; c++) begin
        @(negedge CLK);
        ErrClr    = (c == v.exp_stall) ? v.clr_end : 1'b0;
        FPUDone   = (c == v.done_at);
        FPUResult = (c == v.done_at) ? v.result : $urandom;
        FPUFlags  = (c == v.done_at) ? v.flags : 4'($urandom);
        #1;
        if (c < v.exp_stall) begin
          if (Stall !== 1'b1 || FPUWrite !== 1'b0 || FPUAbort !== 1'b0 || FPUStart !== 1'b0)
            chk("busy", {Stall, FPUWrite, FPUAbort, FPUStart}, 4'b1000);
        end else if (v.exp_write) begin
          chk("wb_stall", Stall, 1'b0);
          chk("wb_start", FPUStart, 1'b0);
          chk("wb_write", FPUWrite, 1'b1);
          chk("wb_abort", FPUAbort, 1'b0);
          chk("wb_fpwa", FPWA, v.dst);
          chk("wb_fpwd", FPWD, v.result);
          chk("wb_flagw", FPFlagW, v.exp_flagw);
          chk("wb_flags", FPFlags, v.flags);
        end else begin
          chk("ab_abort", FPUAbort, 1'b1);
          chk("ab_stall", Stall, 1'b0);
          chk("ab_write", FPUWrite, 1'b0);
          chk("ab_flagw", FPFlagW, 2'b00);
        end
      end
    end
    @(posedge CLK);
    #1;
    chk("opcount", OpCount, v.exp_cnt);
    chk("err", Err, v.exp_err);
    m_cnt = v.exp_cnt;
    m_err = v.exp_err;
    $display("op %0d req=%0b cond=%0b op=%0d dst=%0d s=%0b done_at=%0d write=%0b stall=%0d cnt=%0d err=%0b",
             op_no, v.req, v.cond, v.op, v.dst, v.s, v.done_at, v.exp_write,
             v.exp_stall, v.exp_cnt, v.exp_err);
    op_no++;
  endtask

  initial begin
    Reset = 1'b1; FPUReq = 1'b0; CondEx = 1'b0; FPOp = 2'd0; FPDst = 4'd0; FPS = 1'b0;
    FPUDone = 1'b0; FPUResult = '0; FPUFlags = 4'd0; ErrClr = 1'b0;

    //        req cond op       dst  s  done res           flags   c1 c2  st wr fw     stl cnt err
    tbl[0] = mk(1, 1, FP_MUL, 4'd5, 1, 4,  32'h3F800000, 4'b0100, 0, 0, 1, 1, 2'b11, 5, 4'd1, 0);
    tbl[1] = mk(1, 0, FP_SUB, 4'd3, 1, 2,  32'h00000000, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 4'd1, 0);
    tbl[2] = mk(1, 1, FP_DIV, 4'd7, 1, 99, 32'h00000000, 4'b0000, 0, 0, 1, 0, 2'b00, 9, 4'd1, 1);
    tbl[3] = mk(0, 0, FP_ADD, 4'd0, 0, 1,  32'h00000000, 4'b0000, 1, 0, 0, 0, 2'b00, 0, 4'd1, 0);
    tbl[4] = mk(1, 1, FP_ADD, 4'd9, 0, 8,  32'hA5A5A5A5, 4'b1010, 0, 0, 1, 1, 2'b00, 9, 4'd2, 0);
    tbl[5] = mk(1, 1, FP_SUB, 4'd2, 1, 1,  32'h00000011, 4'b0001, 0, 0, 1, 1, 2'b11, 2, 4'd3, 0);
    tbl[6] = mk(1, 1, FP_MUL, 4'd14, 0, 2, 32'h00000022, 4'b1111, 0, 0, 1, 1, 2'b00, 3, 4'd4, 0);
    tbl[7] = mk(1, 1, FP_DIV, 4'd1, 1, 9,  32'h00000000, 4'b0000, 0, 1, 1, 0, 2'b00, 9, 4'd4, 1);
    tbl[8] = mk(1, 1, FP_ADD, 4'd11, 1, 3, 32'hCAFEF00D, 4'b0110, 1, 0, 1, 1, 2'b11, 4, 4'd5, 0);

    #1;
    chk("reset_outs", all_outs(), 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Spurious done while idle must not produce a write.
    @(negedge CLK);
    FPUReq = 1'b0; CondEx = 1'b0; FPUDone = 1'b1; FPUResult = 32'hDEADBEEF;
    #1;
    chk("spur_stall", Stall, 1'b0);
    @(negedge CLK);
    FPUDone = 1'b0;
    #1;
    chk("spur_write", FPUWrite, 1'b0);
    chk("spur_cnt", OpCount, 4'd5);

    // Reset while BUSY, with request and done still active during reset.
    @(negedge CLK);
    FPUReq = 1'b1; CondEx = 1'b1; FPOp = FP_SUB; FPDst = 4'd4; FPS = 1'b1;
    #1;
    chk("rst_launch", FPUStart, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk("rst_outs_a", all_outs(), 64'd0);
    FPUDone = 1'b1; FPUResult = 32'h12345678;
    @(posedge CLK);
    #1;
    chk("rst_outs_b", all_outs(), 64'd0);
    @(negedge CLK);
    Reset = 1'b0; FPUReq = 1'b0; CondEx = 1'b0; FPUDone = 1'b0;
    #1;
    chk("rst_after", all_outs(), 64'd0);
    m_cnt = 0;
    m_err = 1'b0;
    run_op(model(mk(1, 1, FP_ADD, 4'd6, 1, 2, 32'h40000000, 4'b0010, 0, 0, 0, 0, 2'b00, 0, 4'd0, 0)));

    // Randomized instructions against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v = mk($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 2'($urandom),
             4'($urandom), 1'($urandom), $urandom_range(1, TIMEOUT + 2), $urandom,
             4'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             0, 0, 2'b00, 0, 4'd0, 0);
      run_op(model(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
